// File: rtl/combi_pkg.sv
// Shared types, constants and helpers for the combi core's block-transfer sequencer.
package combi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2
    } seq_state_t;

    // Addressing mode, named after the ARM mnemonics {P,U}.
    typedef enum logic [1:0] {
        IA = 2'd0,
        IB = 2'd1,
        DA = 2'd2,
        DB = 2'd3
    } blk_mode_t;

    localparam int         WORD_BYTES = 4;
    localparam logic [2:0] ARM_OP_BLK = 3'b100;

    // Number of set bits in a 16-entry register list (0..16).
    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    // Map the P (pre-index) and U (up) bits onto the addressing mode.
    function automatic blk_mode_t mode_of(input logic p, input logic u);
        blk_mode_t m;
        case ({p, u})
            2'b01:   m = IA;
            2'b11:   m = IB;
            2'b00:   m = DA;
            2'b10:   m = DB;
            default: m = IA;
        endcase
        return m;
    endfunction

    // True for the ascending modes, whose writeback adds rather than subtracts.
    function automatic logic mode_up(input blk_mode_t m);
        return (m == IA) || (m == IB);
    endfunction

endpackage

// File: rtl/ldm_prienc.sv
// Lowest-set-bit priority encoder over a register list.
module ldm_prienc #(
    parameter int NREGS = 16
) (
    input  logic [NREGS-1:0] vec_i,
    output logic [3:0]       idx_o,
    output logic             any_o
);

    // Scan from the top down so the lowest set bit is the one left standing.
    always_comb begin
        idx_o = 4'd0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = i[3:0];
            end else begin
                idx_o = idx_o;
            end
        end
        any_o = |vec_i;
    end

endmodule

// File: rtl/arm_blockxfer_seq.sv
// LDM/STM micro-op sequencer: one micro-op per listed register, then an optional
// base-writeback micro-op, with Fetch held until the final one issues.
module arm_blockxfer_seq
    import combi_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int OFFW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [31:0]     instr,
    input  logic            StallD,
    input  logic            FlushD,
    output logic            busy,
    output logic            StallF,
    output logic            uopValid,
    output logic [3:0]      uopRd,
    output logic            uopLoad,
    output logic [OFFW-1:0] uopOffset,
    output logic            uopLast,
    output logic            wbValid,
    output logic [3:0]      wbRn,
    output logic [OFFW-1:0] wbDelta
);

    localparam logic [OFFW-1:0] WORD_OFF = OFFW'(WORD_BYTES);

    // Sequencer state and datapath registers.
    seq_state_t        state_q;
    logic [NREGS-1:0]  list_q;
    logic [OFFW-1:0]   off_q;
    logic [4:0]        n_q;
    logic [4:0]        rem_q;
    blk_mode_t         mode_q;
    logic              load_q;
    logic [3:0]        rn_q;
    logic              wb_en_q;

    // Decode of the instruction presented at start.
    logic              start_ok_s;
    logic [NREGS-1:0]  start_list_s;
    logic [3:0]        start_rn_s;
    logic [4:0]        start_n_s;
    blk_mode_t         start_mode_s;
    logic [OFFW-1:0]   start_n4_s;
    logic [OFFW-1:0]   start_off_s;
    logic              start_wb_s;

    // Per-cycle transfer signals.
    logic [3:0]        idx_s;
    logic              any_s;
    logic              last_s;
    logic [NREGS-1:0]  list_clr_s;
    logic [OFFW-1:0]   n4_s;
    logic              unused_s;

    assign start_ok_s   = start && (instr[27:25] == ARM_OP_BLK);
    assign start_list_s = instr[NREGS-1:0];
    assign start_rn_s   = instr[19:16];
    assign start_n_s    = popcount(instr[15:0]);
    assign start_mode_s = mode_of(instr[24], instr[23]);
    assign start_n4_s   = OFFW'(start_n_s) << 2;
    // A load that overwrites its own base keeps the loaded value, so writeback is dropped.
    assign start_wb_s   = instr[21] && !(instr[20] && start_list_s[start_rn_s]);
    assign unused_s     = ^{instr[31:28], instr[22]};

    ldm_prienc #(.NREGS(NREGS)) u_prienc (
        .vec_i (list_q),
        .idx_o (idx_s),
        .any_o (any_s)
    );

    assign list_clr_s = list_q & ~(NREGS'(1) << idx_s);
    assign last_s     = (rem_q == 5'd1);
    assign n4_s       = OFFW'(n_q) << 2;

    // Offset of the first entry; later entries step up by one word each.
    always_comb begin
        case (start_mode_s)
            IA:      start_off_s = {OFFW{1'b0}};
            IB:      start_off_s = WORD_OFF;
            DA:      start_off_s = WORD_OFF - start_n4_s;
            DB:      start_off_s = {OFFW{1'b0}} - start_n4_s;
            default: start_off_s = {OFFW{1'b0}};
        endcase
    end

    // Sequencer FSM and datapath; flush beats stall, stall freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            list_q  <= {NREGS{1'b0}};
            off_q   <= {OFFW{1'b0}};
            n_q     <= 5'd0;
            rem_q   <= 5'd0;
            mode_q  <= IA;
            load_q  <= 1'b0;
            rn_q    <= 4'd0;
            wb_en_q <= 1'b0;
        end else if (FlushD) begin
            state_q <= IDLE;
        end else if (StallD) begin
            state_q <= state_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok_s) begin
                        list_q  <= start_list_s;
                        off_q   <= start_off_s;
                        n_q     <= start_n_s;
                        rem_q   <= start_n_s;
                        mode_q  <= start_mode_s;
                        load_q  <= instr[20];
                        rn_q    <= start_rn_s;
                        wb_en_q <= start_wb_s;
                        state_q <= (start_n_s != 5'd0) ? XFER : IDLE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                XFER: begin
                    list_q <= list_clr_s;
                    off_q  <= off_q + WORD_OFF;
                    rem_q  <= rem_q - 5'd1;
                    if (last_s) begin
                        state_q <= wb_en_q ? WB : IDLE;
                    end else begin
                        state_q <= XFER;
                    end
                end
                WB: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output decode from the registered state; a flush suppresses valids in its own cycle.
    always_comb begin
        busy      = 1'b0;
        StallF    = 1'b0;
        uopValid  = 1'b0;
        uopRd     = 4'd0;
        uopLoad   = 1'b0;
        uopOffset = {OFFW{1'b0}};
        uopLast   = 1'b0;
        wbValid   = 1'b0;
        wbRn      = 4'd0;
        wbDelta   = {OFFW{1'b0}};
        case (state_q)
            IDLE: begin
                StallF = start_ok_s && !StallD && !FlushD;
            end
            XFER: begin
                busy      = 1'b1;
                uopValid  = any_s && !FlushD;
                uopRd     = idx_s;
                uopLoad   = load_q;
                uopOffset = off_q;
                uopLast   = last_s && !FlushD;
                // Fetch may resume only on the last transfer when no writeback follows.
                StallF    = !FlushD && !(last_s && !wb_en_q);
            end
            WB: begin
                busy    = 1'b1;
                wbValid = !FlushD;
                wbRn    = rn_q;
                if (mode_up(mode_q)) begin
                    wbDelta = n4_s;
                end else begin
                    wbDelta = {OFFW{1'b0}} - n4_s;
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
